// File: rtl/udma_hyper_reg_pkg.sv
// Shared address map, timing-bank type and reset constant for the HyperBus uDMA config register file.
package udma_hyper_reg_pkg;

  // Storage width for the RWDS delay code; the top masks it down to DELAY_BIT_WIDTH.
  localparam int DLY_MAX_W = 8;
  localparam int DEST_SIZE = 5;

  localparam logic [4:0] ADDR_PAGE_BOUND = 5'h00;
  localparam logic [4:0] ADDR_T_LAT      = 5'h01;
  localparam logic [4:0] ADDR_EN_LAT_ADD = 5'h02;
  localparam logic [4:0] ADDR_T_CS_MAX   = 5'h03;
  localparam logic [4:0] ADDR_T_RWR      = 5'h04;
  localparam logic [4:0] ADDR_RWDS_DLY   = 5'h05;
  localparam logic [4:0] ADDR_T_VLAT     = 5'h06;
  localparam logic [4:0] ADDR_MEM_SEL    = 5'h07;
  localparam logic [4:0] ADDR_DEV_SEL    = 5'h08;
  localparam logic [4:0] ADDR_ALLOC      = 5'h09;
  localparam logic [4:0] ADDR_DEST       = 5'h0A;
  localparam logic [4:0] ADDR_RELEASE    = 5'h0B;
  localparam logic [4:0] ADDR_PENDING    = 5'h0C;
  localparam logic [4:0] ADDR_LOCK       = 5'h0D;

  typedef struct packed {
    logic [2:0]           page_bound;
    logic [4:0]           t_lat;
    logic                 en_lat_add;
    logic [31:0]          t_cs_max;
    logic [31:0]          t_rwr;
    logic [DLY_MAX_W-1:0] rwds_dly;
    logic [3:0]           t_vlat;
    logic [1:0]           mem_sel;
  } cfg_bank_t;

  localparam cfg_bank_t CFG_BANK_RST = '{
    page_bound: 3'd0,
    t_lat:      5'd6,
    en_lat_add: 1'b1,
    t_cs_max:   32'd665,
    t_rwr:      32'd6,
    rwds_dly:   8'd2,
    t_vlat:     4'd3,
    mem_sel:    2'd0
  };

  function automatic cfg_bank_t bank_write(input cfg_bank_t bank, input logic [4:0] addr,
                                           input logic [31:0] data,
                                           input logic [DLY_MAX_W-1:0] dly_mask);
    cfg_bank_t b;
    b = bank;
    case (addr)
      ADDR_PAGE_BOUND: b.page_bound = data[2:0];
      ADDR_T_LAT:      b.t_lat      = data[4:0];
      ADDR_EN_LAT_ADD: b.en_lat_add = data[0];
      ADDR_T_CS_MAX:   b.t_cs_max   = data;
      ADDR_T_RWR:      b.t_rwr      = data;
      ADDR_RWDS_DLY:   b.rwds_dly   = data[DLY_MAX_W-1:0] & dly_mask;
      ADDR_T_VLAT:     b.t_vlat     = data[3:0];
      ADDR_MEM_SEL:    b.mem_sel    = data[1:0];
      default:         b = bank;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] bank_read(input cfg_bank_t bank, input logic [4:0] addr);
    logic [31:0] d;
    d = '0;
    case (addr)
      ADDR_PAGE_BOUND: d = 32'(bank.page_bound);
      ADDR_T_LAT:      d = 32'(bank.t_lat);
      ADDR_EN_LAT_ADD: d = 32'(bank.en_lat_add);
      ADDR_T_CS_MAX:   d = bank.t_cs_max;
      ADDR_T_RWR:      d = bank.t_rwr;
      ADDR_RWDS_DLY:   d = 32'(bank.rwds_dly);
      ADDR_T_VLAT:     d = 32'(bank.t_vlat);
      ADDR_MEM_SEL:    d = 32'(bank.mem_sel);
      default:         d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/udma_hyper_id_alloc.sv
// Reserving transaction-ID allocator: lowest free channel is handed out once and held until
// the controller raises its busy flag or software releases it.
module udma_hyper_id_alloc #(
  parameter int NB_CH = 4,
  parameter int ID_W  = $clog2(NB_CH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NB_CH-1:0] busy_vec_i,
  input  logic             alloc_req_i,
  input  logic             rel_valid_i,
  input  logic [NB_CH-1:0] rel_mask_i,
  output logic             alloc_found_o,
  output logic [ID_W-1:0]  alloc_id_o,
  output logic [NB_CH-1:0] rsv_o
);

  logic [NB_CH-1:0] busy_q;
  logic [NB_CH-1:0] rsv_q;
  logic [NB_CH-1:0] rsv_d;
  logic [NB_CH-1:0] free;

  assign free  = ~busy_vec_i & ~rsv_q;
  assign rsv_o = rsv_q;

  // Downward scan so the lowest free index is the one left standing.
  always_comb begin
    alloc_found_o = 1'b0;
    alloc_id_o    = '0;
    for (int i = NB_CH - 1; i >= 0; i--) begin
      if (free[i]) begin
        alloc_found_o = 1'b1;
        alloc_id_o    = ID_W'(i);
      end
    end
  end

  // Reserving last means a same-cycle release of the handed-out ID loses.
  always_comb begin
    rsv_d = rsv_q & ~(busy_vec_i & ~busy_q);
    if (rel_valid_i) rsv_d = rsv_d & ~rel_mask_i;
    if (alloc_req_i && alloc_found_o) rsv_d[alloc_id_o] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      rsv_q  <= '0;
    end else begin
      busy_q <= busy_vec_i;
      rsv_q  <= rsv_d;
    end
  end

endmodule

// File: rtl/udma_hyper_reg_if_multi.sv
// HyperBus uDMA config register file with per-device shadow/active timing banks and an ID allocator.
// Optional sticky write lock is built when HYPER_REG_LOCK_EN is defined.
module udma_hyper_reg_if_multi
  import udma_hyper_reg_pkg::*;
#(
  parameter int NB_CH           = 4,
  parameter int NB_DEV          = 2,
  parameter int DELAY_BIT_WIDTH = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [31:0]                  cfg_data_i,
  input  logic [4:0]                   cfg_addr_i,
  input  logic                         cfg_valid_i,
  input  logic                         cfg_reg_rwn_i,
  output logic [31:0]                  cfg_data_o,
  output logic                         cfg_ready_o,
  input  logic [NB_CH-1:0]             busy_vec_i,
  input  logic [NB_DEV-1:0]            dev_busy_i,
  output cfg_bank_t [NB_DEV-1:0]       cfg_bank_o,
  output logic [DEST_SIZE-1:0]         cfg_rx_dest_o,
  output logic [DEST_SIZE-1:0]         cfg_tx_dest_o,
  output logic [NB_CH-1:0]             alloc_rsv_o
);

  localparam int DEV_W = (NB_DEV > 1) ? $clog2(NB_DEV) : 1;
  localparam int ID_W  = $clog2(NB_CH);
  localparam logic [DLY_MAX_W-1:0] DLY_MASK = DLY_MAX_W'((64'd1 << DELAY_BIT_WIDTH) - 64'd1);

  cfg_bank_t [NB_DEV-1:0] shadow_q;
  cfg_bank_t [NB_DEV-1:0] active_q;
  logic [NB_DEV-1:0]      pending_q;
  logic [NB_DEV-1:0]      shadow_wr;
  logic [NB_DEV-1:0]      commit;
  logic [DEV_W-1:0]       dev_sel_q;
  logic [DEST_SIZE-1:0]   rx_dest_q;
  logic [DEST_SIZE-1:0]   tx_dest_q;
  logic                   wr;
  logic                   bank_wr;
  logic                   locked;
  logic                   alloc_found;
  logic [ID_W-1:0]        alloc_id;

  assign wr          = cfg_valid_i & ~cfg_reg_rwn_i;
  assign bank_wr     = wr & ~locked & (cfg_addr_i <= ADDR_MEM_SEL);
  assign commit      = pending_q & ~dev_busy_i;
  assign cfg_ready_o = 1'b1;
  assign cfg_bank_o  = active_q;
  assign cfg_rx_dest_o = rx_dest_q;
  assign cfg_tx_dest_o = tx_dest_q;

`ifdef HYPER_REG_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lock_q <= 1'b0;
    else if (wr && cfg_addr_i == ADDR_LOCK && cfg_data_i[0]) lock_q <= 1'b1;
  end

  assign locked = lock_q;
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    for (int d = 0; d < NB_DEV; d++) shadow_wr[d] = bank_wr && (dev_sel_q == DEV_W'(d));
  end

  // Commit copies the pre-write shadow, so a coincident write keeps its pending flag for the next idle cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q  <= {NB_DEV{CFG_BANK_RST}};
      active_q  <= {NB_DEV{CFG_BANK_RST}};
      pending_q <= '0;
    end else begin
      for (int d = 0; d < NB_DEV; d++) begin
        if (commit[d]) active_q[d] <= shadow_q[d];
        if (shadow_wr[d]) shadow_q[d] <= bank_write(shadow_q[d], cfg_addr_i, cfg_data_i, DLY_MASK);
      end
      pending_q <= shadow_wr | (pending_q & ~commit);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dev_sel_q <= '0;
      rx_dest_q <= '0;
      tx_dest_q <= '0;
    end else if (wr && !locked) begin
      if (cfg_addr_i == ADDR_DEV_SEL && cfg_data_i < 32'(NB_DEV)) dev_sel_q <= cfg_data_i[DEV_W-1:0];
      if (cfg_addr_i == ADDR_DEST) begin
        rx_dest_q <= cfg_data_i[DEST_SIZE-1:0];
        tx_dest_q <= cfg_data_i[8+:DEST_SIZE];
      end
    end
  end

  udma_hyper_id_alloc #(
    .NB_CH (NB_CH),
    .ID_W  (ID_W)
  ) u_id_alloc (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .busy_vec_i    (busy_vec_i),
    .alloc_req_i   (cfg_valid_i & cfg_reg_rwn_i & (cfg_addr_i == ADDR_ALLOC)),
    .rel_valid_i   (wr & (cfg_addr_i == ADDR_RELEASE)),
    .rel_mask_i    (cfg_data_i[NB_CH-1:0]),
    .alloc_found_o (alloc_found),
    .alloc_id_o    (alloc_id),
    .rsv_o         (alloc_rsv_o)
  );

  always_comb begin
    cfg_data_o = '0;
    if (cfg_addr_i <= ADDR_MEM_SEL) begin
      cfg_data_o = bank_read(shadow_q[dev_sel_q], cfg_addr_i);
    end else begin
      case (cfg_addr_i)
        ADDR_DEV_SEL: cfg_data_o = 32'(dev_sel_q);
        ADDR_ALLOC:   cfg_data_o = alloc_found ? 32'(alloc_id) : 32'h8000_0000;
        ADDR_DEST: begin
          cfg_data_o[DEST_SIZE-1:0] = rx_dest_q;
          cfg_data_o[8+:DEST_SIZE]  = tx_dest_q;
        end
        ADDR_PENDING: cfg_data_o = 32'(pending_q);
        ADDR_LOCK:    cfg_data_o = 32'(locked);
        default:      cfg_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_hyper_reg_if_multi.sv
// Directed, table-driven bench for udma_hyper_reg_if_multi; lock checks follow HYPER_REG_LOCK_EN.
module tb_udma_hyper_reg_if_multi;
  import udma_hyper_reg_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [31:0]          cfg_data_i;
  logic [4:0]           cfg_addr_i;
  logic                 cfg_valid_i;
  logic                 cfg_reg_rwn_i;
  logic [31:0]          cfg_data_o;
  logic                 cfg_ready_o;
  logic [3:0]           busy_vec_i;
  logic [1:0]           dev_busy_i;
  cfg_bank_t [1:0]      cfg_bank_o;
  logic [DEST_SIZE-1:0] cfg_rx_dest_o;
  logic [DEST_SIZE-1:0] cfg_tx_dest_o;
  logic [3:0]           alloc_rsv_o;

  logic [3:0] a_busy;
  logic       a_req;
  logic       a_rel_v;
  logic [3:0] a_rel_m;
  logic       a_found;
  logic [1:0] a_id;
  logic [3:0] a_rsv;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  udma_hyper_reg_if_multi #(
    .NB_CH           (4),
    .NB_DEV          (2),
    .DELAY_BIT_WIDTH (3)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cfg_data_i    (cfg_data_i),
    .cfg_addr_i    (cfg_addr_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_reg_rwn_i (cfg_reg_rwn_i),
    .cfg_data_o    (cfg_data_o),
    .cfg_ready_o   (cfg_ready_o),
    .busy_vec_i    (busy_vec_i),
    .dev_busy_i    (dev_busy_i),
    .cfg_bank_o    (cfg_bank_o),
    .cfg_rx_dest_o (cfg_rx_dest_o),
    .cfg_tx_dest_o (cfg_tx_dest_o),
    .alloc_rsv_o   (alloc_rsv_o)
  );

  // Standalone allocator instance: a same-cycle reserve and release cannot be issued over the single cfg bus.
  udma_hyper_id_alloc #(
    .NB_CH (4),
    .ID_W  (2)
  ) u_alloc (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .busy_vec_i    (a_busy),
    .alloc_req_i   (a_req),
    .rel_valid_i   (a_rel_v),
    .rel_mask_i    (a_rel_m),
    .alloc_found_o (a_found),
    .alloc_id_o    (a_id),
    .rsv_o         (a_rsv)
  );

  typedef struct {
    logic        valid;
    logic        rwn;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        check;
    logic [31:0] exp;
  } vec_t;

  vec_t      vecs[18];
  cfg_bank_t exp_rst;

  task automatic applyStimulus(input logic valid, input logic rwn, input logic [4:0] addr,
                               input logic [31:0] data);
    @(negedge clk_i);
    cfg_valid_i   = valid;
    cfg_reg_rwn_i = rwn;
    cfg_addr_i    = addr;
    cfg_data_i    = data;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic checkData(input string name, input logic [31:0] expected);
    checkOutput(name, 128'(cfg_data_o), 128'(expected));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] alloc_exp [4];

    exp_rst = '{page_bound: 3'd0, t_lat: 5'd6, en_lat_add: 1'b1, t_cs_max: 32'd665,
                t_rwr: 32'd6, rwds_dly: 8'd2, t_vlat: 4'd3, mem_sel: 2'd0};

    vecs[0]  = '{1'b1, 1'b1, 5'h00, 32'h0,        1'b1, 32'd0};
    vecs[1]  = '{1'b1, 1'b1, 5'h01, 32'h0,        1'b1, 32'd6};
    vecs[2]  = '{1'b1, 1'b1, 5'h02, 32'h0,        1'b1, 32'd1};
    vecs[3]  = '{1'b1, 1'b1, 5'h03, 32'h0,        1'b1, 32'd665};
    vecs[4]  = '{1'b1, 1'b1, 5'h04, 32'h0,        1'b1, 32'd6};
    vecs[5]  = '{1'b1, 1'b1, 5'h05, 32'h0,        1'b1, 32'd2};
    vecs[6]  = '{1'b1, 1'b1, 5'h06, 32'h0,        1'b1, 32'd3};
    vecs[7]  = '{1'b1, 1'b1, 5'h07, 32'h0,        1'b1, 32'd0};
    vecs[8]  = '{1'b1, 1'b1, 5'h08, 32'h0,        1'b1, 32'd0};
    vecs[9]  = '{1'b1, 1'b1, 5'h0A, 32'h0,        1'b1, 32'd0};
    vecs[10] = '{1'b1, 1'b1, 5'h0C, 32'h0,        1'b1, 32'd0};
    vecs[11] = '{1'b1, 1'b1, 5'h0E, 32'h0,        1'b1, 32'd0};
    vecs[12] = '{1'b1, 1'b0, 5'h0A, 32'h0000_0305, 1'b0, 32'd0};
    vecs[13] = '{1'b1, 1'b1, 5'h0A, 32'h0,        1'b1, 32'h0000_0305};
    vecs[14] = '{1'b1, 1'b0, 5'h1F, 32'hFFFF_FFFF, 1'b0, 32'd0};
    vecs[15] = '{1'b1, 1'b1, 5'h0C, 32'h0,        1'b1, 32'd0};
    vecs[16] = '{1'b1, 1'b0, 5'h05, 32'h0000_00FF, 1'b0, 32'd0};
    vecs[17] = '{1'b1, 1'b1, 5'h05, 32'h0,        1'b1, 32'd7};

    alloc_exp[0] = 32'd1;
    alloc_exp[1] = 32'd2;
    alloc_exp[2] = 32'd3;
    alloc_exp[3] = 32'h8000_0000;

    rst_ni = 1'b0;
    cfg_valid_i = 1'b0; cfg_reg_rwn_i = 1'b1; cfg_addr_i = '0; cfg_data_i = '0;
    busy_vec_i = '0; dev_busy_i = '0;
    a_busy = '0; a_req = 1'b0; a_rel_v = 1'b0; a_rel_m = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;

    checkOutput("rst_bank0", 128'(cfg_bank_o[0]), 128'(exp_rst));
    checkOutput("rst_bank1", 128'(cfg_bank_o[1]), 128'(exp_rst));
    checkOutput("rst_rsv", 128'(alloc_rsv_o), 128'(4'b0000));
    checkOutput("ready", 128'(cfg_ready_o), 128'(1'b1));

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].rwn, vecs[i].addr, vecs[i].data);
      if (vecs[i].check) checkData($sformatf("vec%0d", i), vecs[i].exp);
    end
    checkOutput("rx_dest", 128'(cfg_rx_dest_o), 128'(5'd5));
    checkOutput("tx_dest", 128'(cfg_tx_dest_o), 128'(5'd3));
    applyStimulus(1'b0, 1'b1, 5'h00, 32'h0);

    // Commit held off while device 0 is busy.
    dev_busy_i = 2'b01;
    applyStimulus(1'b1, 1'b0, 5'h01, 32'd9);
    applyStimulus(1'b1, 1'b1, 5'h0C, 32'h0);
    checkData("pend_busy", 32'd1);
    checkOutput("act_tlat_busy", 128'(cfg_bank_o[0].t_lat), 128'(5'd6));
    applyStimulus(1'b0, 1'b1, 5'h01, 32'h0);
    checkOutput("act_tlat_busy2", 128'(cfg_bank_o[0].t_lat), 128'(5'd6));
    checkData("shadow_tlat", 32'd9);
    dev_busy_i = 2'b00;
    #1;
    checkOutput("act_tlat_pre", 128'(cfg_bank_o[0].t_lat), 128'(5'd6));
    applyStimulus(1'b0, 1'b1, 5'h0C, 32'h0);
    checkOutput("act_tlat_commit", 128'(cfg_bank_o[0].t_lat), 128'(5'd9));
    checkOutput("act_rwds_commit", 128'(cfg_bank_o[0].rwds_dly), 128'(8'd7));
    checkData("pend_clear", 32'd0);
    checkOutput("dev1_untouched", 128'(cfg_bank_o[1].t_lat), 128'(5'd6));

    busy_vec_i = 4'b0001;
    applyStimulus(1'b0, 1'b1, 5'h09, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 5'h09, 32'h0);
      checkData($sformatf("alloc%0d", i), alloc_exp[i]);
    end
    applyStimulus(1'b0, 1'b1, 5'h09, 32'h0);
    checkOutput("rsv_full", 128'(alloc_rsv_o), 128'(4'b1110));
    checkData("alloc_none", 32'h8000_0000);
    busy_vec_i = 4'b0101;
    applyStimulus(1'b0, 1'b1, 5'h09, 32'h0);
    checkOutput("rsv_busy_edge", 128'(alloc_rsv_o), 128'(4'b1010));
    applyStimulus(1'b1, 1'b0, 5'h0B, 32'h0000_0008);
    applyStimulus(1'b1, 1'b1, 5'h09, 32'h0);
    checkOutput("rsv_release", 128'(alloc_rsv_o), 128'(4'b0010));
    checkData("alloc_after_rel", 32'd3);
    applyStimulus(1'b0, 1'b1, 5'h09, 32'h0);
    checkOutput("rsv_realloc", 128'(alloc_rsv_o), 128'(4'b1010));

    // Reserve and release of the same ID in one cycle: reserve wins.
    @(negedge clk_i);
    a_req = 1'b1;
    #1;
    checkOutput("sub_id0", 128'({a_found, a_id}), 128'({1'b1, 2'd0}));
    @(negedge clk_i);
    a_rel_v = 1'b1; a_rel_m = 4'b0010;
    #1;
    checkOutput("sub_id1", 128'({a_found, a_id}), 128'({1'b1, 2'd1}));
    @(negedge clk_i);
    a_req = 1'b0; a_rel_v = 1'b0; a_rel_m = '0;
    #1;
    checkOutput("sub_rsv_win", 128'(a_rsv), 128'(4'b0011));

    applyStimulus(1'b1, 1'b0, 5'h08, 32'd2);
    applyStimulus(1'b1, 1'b1, 5'h08, 32'h0);
    checkData("devsel_drop", 32'd0);
    applyStimulus(1'b1, 1'b0, 5'h08, 32'd1);
    dev_busy_i = 2'b10;
    applyStimulus(1'b1, 1'b0, 5'h01, 32'd7);
    dev_busy_i = 2'b00;
    applyStimulus(1'b1, 1'b0, 5'h03, 32'd100);
    applyStimulus(1'b1, 1'b1, 5'h0C, 32'h0);
    checkData("pend_coincident", 32'd2);
    checkOutput("dev1_tlat_old", 128'(cfg_bank_o[1].t_lat), 128'(5'd7));
    checkOutput("dev1_cs_old", 128'(cfg_bank_o[1].t_cs_max), 128'(32'd665));
    applyStimulus(1'b1, 1'b1, 5'h03, 32'h0);
    checkOutput("dev1_cs_new", 128'(cfg_bank_o[1].t_cs_max), 128'(32'd100));
    checkOutput("dev0_cs", 128'(cfg_bank_o[0].t_cs_max), 128'(32'd665));
    checkData("dev1_shadow_cs", 32'd100);

    applyStimulus(1'b1, 1'b0, 5'h0D, 32'd1);
    applyStimulus(1'b1, 1'b0, 5'h04, 32'd20);
    applyStimulus(1'b1, 1'b1, 5'h04, 32'h0);
`ifdef HYPER_REG_LOCK_EN
    checkData("locked_trwr", 32'd6);
    applyStimulus(1'b1, 1'b1, 5'h0D, 32'h0);
    checkData("lock_rd", 32'd1);
    applyStimulus(1'b1, 1'b0, 5'h08, 32'd0);
    applyStimulus(1'b1, 1'b1, 5'h08, 32'h0);
    checkData("locked_devsel", 32'd1);
`else
    checkData("unlocked_trwr", 32'd20);
    applyStimulus(1'b1, 1'b1, 5'h0D, 32'h0);
    checkData("lock_rd", 32'd0);
`endif

    dev_busy_i = 2'b11;
    applyStimulus(1'b1, 1'b0, 5'h00, 32'd5);
    applyStimulus(1'b0, 1'b1, 5'h0C, 32'h0);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("mid_rst_bank1", 128'(cfg_bank_o[1]), 128'(exp_rst));
    checkOutput("mid_rst_rsv", 128'(alloc_rsv_o), 128'(4'b0000));
    checkData("mid_rst_pend", 32'd0);
    cfg_addr_i = 5'h0D;
    #1;
    checkData("mid_rst_lock", 32'd0);
    cfg_addr_i = 5'h08;
    #1;
    checkData("mid_rst_devsel", 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    dev_busy_i = 2'b00;
    applyStimulus(1'b1, 1'b1, 5'h0D, 32'h0);
    checkData("post_rst_lock", 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
